if_id_queue: RTL and testbench

Instruction fetch queue between the PC register / instruction memory read and the decode stage. Captures each fetched {PC, instruction} pair and holds it in a small FIFO. Presents pairs to decode through a valid/ready handshake. Its `in_ready` output drives the PC register's write enable, so the PC advances only when the fetched pair has been accepted. A flush input discards all queued pairs on a branch or jump redirect.

---
 rtl/if_id_queue.sv | 119 +++++++++++
 tb/tb_if_id_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO of {PC, instruction, misalign} entries with a valid/ready handshake.
// Define IF_ID_QUEUE_BYPASS_EN to forward a pair straight through an empty queue.
module if_id_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              instr_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              pc_out,
  output logic [31:0]              instr_out,
  output logic                     misalign_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  function automatic logic misalign_of(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic          mis_mem_r   [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic push_s;
  logic pop_s;
  logic store_s;
  logic drain_s;
  logic bypass_s;
  logic empty_s;

  // Handshake decode; in_ready never looks at out_ready so decode cannot reach the PC combinationally.
  always_comb begin
    empty_s  = (count_r == {CW{1'b0}});
    in_ready = (count_r < FULL_CNT) && !flush;
    push_s   = in_valid && in_ready;
`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass_s = empty_s && in_valid && !flush;
`else
    bypass_s = 1'b0;
`endif
    out_valid = !empty_s || bypass_s;
    pop_s     = out_valid && out_ready;
    // A bypassed pair consumed in the same cycle is never written.
    store_s   = push_s && !(bypass_s && out_ready);
    drain_s   = pop_s && !bypass_s;
  end

  // Head presentation: stored entry first, then bypass, otherwise a NOP bubble.
  always_comb begin
    pc_out       = 32'h0000_0000;
    instr_out    = NOP_INSTR;
    misalign_out = 1'b0;
    if (!empty_s) begin
      pc_out       = pc_mem_r[rd_ptr_r];
      instr_out    = instr_mem_r[rd_ptr_r];
      misalign_out = mis_mem_r[rd_ptr_r];
    end else if (bypass_s) begin
      pc_out       = pc_in;
      instr_out    = instr_in;
      misalign_out = misalign_of(pc_in);
    end else begin
      pc_out       = 32'h0000_0000;
      instr_out    = NOP_INSTR;
      misalign_out = 1'b0;
    end
  end

  // Pointer and occupancy state; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({store_s, drain_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage is deliberately left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (store_s) begin
      pc_mem_r[wr_ptr_r]    <= pc_in;
      instr_mem_r[wr_ptr_r] <= instr_in;
      mis_mem_r[wr_ptr_r]   <= misalign_of(pc_in);
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model plus directed scenarios.
module tb_if_id_queue;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          res;
  logic [31:0]   pc_in, instr_in;
  logic          in_valid, in_ready, flush;
  logic          out_valid, out_ready;
  logic [31:0]   pc_out, instr_out;
  logic          misalign_out;
  logic [CW-1:0] count;

  int checks = 0;
  int fails  = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .res(res), .pc_in(pc_in), .instr_in(instr_in), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instr_out(instr_out), .misalign_out(misalign_out), .count(count)
  );

  always #5 clk = ~clk;

  wire [CW+66:0] obs = {out_valid, pc_out, instr_out, misalign_out, in_ready, count};

  // Expected outputs for the current inputs, derived from the model FIFO contents.
  function automatic logic [CW+66:0] exp_vec();
    logic v;
    logic [31:0] p, i;
    logic rdy;
    v = 1'b0; p = 32'h0; i = NOP;
    if (q_pc.size() > 0) begin
      v = 1'b1; p = q_pc[0]; i = q_ins[0];
    end else if (BYP && in_valid && !flush) begin
      v = 1'b1; p = pc_in; i = instr_in;
    end
    rdy = (q_pc.size() < DEPTH) && !flush;
    return {v, p, i, (p[1] | p[0]), rdy, CW'(q_pc.size())};
  endfunction

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid = v; pc_in = p; instr_in = ins; out_ready = ordy; flush = fl;
  endtask

  // Advance one clock and apply the queue semantics to the model.
  task automatic tick();
    bit full, byp;
    @(posedge clk);
    if (flush) begin
      q_pc.delete(); q_ins.delete();
    end else begin
      full = (q_pc.size() == DEPTH);
      byp  = BYP && (q_pc.size() == 0) && in_valid;
      if (!(byp && out_ready)) begin
        if (out_ready && q_pc.size() > 0) begin
          void'(q_pc.pop_front()); void'(q_ins.pop_front());
        end
        if (in_valid && !full) begin
          q_pc.push_back(pc_in); q_ins.push_back(instr_in);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    res = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    res = 1'b1;
    #1;
    checks++;
    if ({in_ready, count} !== {1'b1, CW'(0)}) begin
      fails++; $display("FAIL reset_release got rdy=%b cnt=%0d exp rdy=1 cnt=0", in_ready, count);
    end
    drive(1'b1, 32'h0000_0002, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0004, 32'h9abc_def0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 res = 1'b0;
    #1;
    checks++;
    if ({out_valid, pc_out, instr_out, misalign_out, count} !== {1'b0, 32'h0, NOP, 1'b0, CW'(0)}) begin
      fails++;
      $display("FAIL reset_async got v=%b pc=%h ins=%h mis=%b cnt=%0d exp v=0 pc=0 ins=%h mis=0 cnt=0",
               out_valid, pc_out, instr_out, misalign_out, count, NOP);
    end
    q_pc.delete(); q_ins.delete();
    @(negedge clk);
    res = 1'b1;
    #1;
    checks++;
    if ({in_ready, count, out_valid} !== {1'b1, CW'(0), 1'b0}) begin
      fails++; $display("FAIL reset_idle got rdy=%b cnt=%0d v=%b exp 1 0 0", in_ready, count, out_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(4 * i), $urandom(), 1'b0, 1'b0);
      #1; checks++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL fill_%0d got %h exp %h", i, obs, exp_vec()); end
      tick();
    end
    drive(1'b1, 32'(4 * DEPTH), $urandom(), 1'b0, 1'b0);
    #1; checks++;
    if ({in_ready, count, pc_out} !== {1'b0, CW'(DEPTH), 32'h0}) begin
      fails++; $display("FAIL fill_full got rdy=%b cnt=%0d pc=%h exp rdy=0 cnt=%0d pc=0", in_ready, count, pc_out, DEPTH);
    end
    tick();
    #1; checks++;
    if ({count, pc_out} !== {CW'(DEPTH), 32'h0}) begin
      fails++; $display("FAIL fill_blocked got cnt=%0d pc=%h exp cnt=%0d pc=0", count, pc_out, DEPTH);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1; checks++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL fill_drain_%0d got %h exp %h", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_streaming();
    logic [31:0] seen[$];
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 32'(4 * i), $urandom(), 1'b1, 1'b0);
      else       drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1; checks++;
      if (obs !== exp_vec() || count > CW'(1)) begin
        fails++; $display("FAIL stream_%0d got %h exp %h", i, obs, exp_vec());
      end
      if (out_valid) seen.push_back(pc_out);
      tick();
    end
    checks++;
    if (seen.size() != 8) begin
      fails++; $display("FAIL stream_len got %0d exp 8", seen.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seen[i] !== 32'(4 * i)) begin
          fails++; $display("FAIL stream_order_%0d got %h exp %h", i, seen[i], 4 * i);
        end
      end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0, $urandom(), 1'b0, 1'b0); tick();
    drive(1'b1, 32'h4, $urandom(), 1'b0, 1'b0); tick();
    drive(1'b1, 32'h10, $urandom(), 1'b1, 1'b1);
    #1; checks++;
    if ({in_ready, out_valid, count} !== {1'b0, 1'b1, CW'(2)}) begin
      fails++; $display("FAIL flush_cycle got rdy=%b v=%b cnt=%0d exp 0 1 2", in_ready, out_valid, count);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1; checks++;
    if ({count, out_valid, instr_out} !== {CW'(0), 1'b0, 32'h0000_0013}) begin
      fails++; $display("FAIL flush_after got cnt=%0d v=%b ins=%h exp 0 0 00000013", count, out_valid, instr_out);
    end
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 32'(32'h20 + 4 * i), $urandom(), 1'b1, 1'b0);
      #1; checks++;
      if (obs !== exp_vec() || (out_valid && pc_out == 32'h10)) begin
        fails++; $display("FAIL flush_resume_%0d got %h exp %h", i, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h6, 32'h00A0_0093, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8, $urandom(), 1'b0, 1'b0);
    #1; checks++;
    if ({misalign_out, pc_out, instr_out} !== {1'b1, 32'h6, 32'h00A0_0093}) begin
      fails++; $display("FAIL misalign_head got mis=%b pc=%h ins=%h exp 1 00000006 00a00093", misalign_out, pc_out, instr_out);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    #1; checks++;
    if ({misalign_out, pc_out} !== {1'b0, 32'h8}) begin
      fails++; $display("FAIL misalign_next got mis=%b pc=%h exp 0 00000008", misalign_out, pc_out);
    end
    tick();
  endtask

  task automatic test_wrap();
    int n;
    for (int b = 0; b < 10; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
        #1; checks++;
        if (obs !== exp_vec()) begin fails++; $display("FAIL wrap_push_%0d_%0d got %h exp %h", b, i, obs, exp_vec()); end
        tick();
      end
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1; checks++;
        if (obs !== exp_vec()) begin fails++; $display("FAIL wrap_pop_%0d_%0d got %h exp %h", b, i, obs, exp_vec()); end
        tick();
      end
    end
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), $urandom(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0);
      #1; checks++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL random_%0d got %h exp %h", i, obs, exp_vec()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_flush();
    test_misalign();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
